// File: rtl/ba_pkg.sv
// Shared definitions for the two-requester arbiter companion buffer.
package ba_pkg;

    localparam int N_REQ = 2;

    typedef logic src_idx_t;

    function automatic src_idx_t onehot_to_idx(input logic [N_REQ-1:0] oh);
        src_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = src_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ba_req_buf_if.sv
// Source-side, arbiter-side and output-side signals of ba_req_buf.
interface ba_req_buf_if
    import ba_pkg::*;
#(
    parameter int DW = 8
);
    logic [N_REQ-1:0]    in_valid;
    logic [N_REQ*DW-1:0] in_data;
    logic [N_REQ-1:0]    in_ready;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    grant;
    logic                ack;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    src_idx_t            out_src;
    logic                grant_err;

    modport master (
        output in_valid, in_data, grant, out_ready,
        input  in_ready, req, ack, out_valid, out_data, out_src, grant_err
    );

    modport slave (
        input  in_valid, in_data, grant, out_ready,
        output in_ready, req, ack, out_valid, out_data, out_src, grant_err
    );
endinterface

// File: rtl/ba_sync_fifo.sv
// Small synchronous FIFO with combinational head read and registered count.
module ba_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; only entries below the count are ever visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/ba_req_buf.sv
// Per-source request FIFOs feeding a round-robin arbiter, with grant decode
// and a single registered output stage.
module ba_req_buf
    import ba_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    ba_req_buf_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0]    head0, head1;
    logic             full0, full1;
    logic             empty0, empty1;
    logic [CW-1:0]    count0, count1;
    logic [N_REQ-1:0] push;
    logic             pop0, pop1;
    logic             err_cond;
    logic             grant_ok;
    logic             load;
    src_idx_t         g;

    logic             out_valid_q;
    logic [DW-1:0]    out_data_q;
    src_idx_t         out_src_q;
    logic             grant_err_q;

    assign bus.in_ready = {~full1, ~full0};
    assign push         = bus.in_valid & bus.in_ready;
    assign bus.req      = {count1 != '0, count0 != '0};

    // A grant is usable only if it is one-hot and points at a non-empty FIFO.
    assign err_cond = (bus.grant == 2'b11) || ((bus.grant & ~bus.req) != '0);
    assign grant_ok = (bus.grant != '0) && !err_cond;
    assign g        = onehot_to_idx(bus.grant);
    assign load     = grant_ok && (!out_valid_q || bus.out_ready);
    assign bus.ack  = load;

    assign pop0 = load && (g == 1'b0) && !empty0;
    assign pop1 = load && (g == 1'b1) && !empty1;

    ba_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push[0]),
        .pop   (pop0),
        .wdata (bus.in_data[0 +: DW]),
        .rdata (head0),
        .full  (full0),
        .empty (empty0),
        .count (count0)
    );

    ba_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push[1]),
        .pop   (pop1),
        .wdata (bus.in_data[DW +: DW]),
        .rdata (head1),
        .full  (full1),
        .empty (empty1),
        .count (count1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            grant_err_q <= 1'b0;
        end else begin
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= (g == 1'b1) ? head1 : head0;
                out_src_q   <= g;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (err_cond) grant_err_q <= 1'b1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.grant_err = grant_err_q;

endmodule

// File: doc/ba_req_buf.md
Name: ba_req_buf

Overview:
- Upstream/downstream companion for the 2-requester round-robin arbiter.
- Buffers write traffic from two sources in per-port FIFOs and presents the non-empty status of each FIFO as `req[1:0]` to the arbiter.
- Consumes the arbiter's one-hot `grant` and moves the granted head entry into a single registered output stage.
- Returns `ack` to the arbiter so its round-robin token advances only when a transfer is actually taken.

Parameters:
- DW, 8, data width of each entry.
- DEPTH, 4, entries per input FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  2  per-source push request; bit i belongs to source i.
- in_data  input  2*DW  source i data in bits [i*DW +: DW].
- in_ready  output  2  per-source FIFO not full.
- req  output  2  to arbiter; req[i] = FIFO i non-empty.
- grant  input  2  from arbiter; one-hot or zero, combinational from req and the arbiter token.
- ack  output  1  to arbiter; 1-cycle pulse, high in each cycle a granted entry is loaded.
- out_valid  output  1  output register holds an entry.
- out_ready  input  1  downstream accepts the entry.
- out_data  output  DW  registered data.
- out_src  output  1  source index of out_data.
- grant_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, `rst`=1):
  - Both FIFOs empty; all pointers and counts are 0.
  - out_valid=0, out_data=0, out_src=0, grant_err=0.
  - Combinational results of reset state: req=00, ack=0, in_ready=11.
- FIFO i:
  - Push when in_valid[i] && in_ready[i].
  - in_ready[i] = count_i != DEPTH.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, no push is accepted even if a pop occurs in the same cycle; in_ready depends only on the registered count.
  - Head data is read combinationally from the current read pointer.
- req[i] = count_i != 0, purely from registered state, so `req` never depends on `ack`.
- Output register load condition: load = grant_ok && (!out_valid || out_ready).
  - grant_ok = grant is exactly one-hot and req at the granted index is 1.
- On load:
  - out_data <= head of FIFO g, out_src <= g, out_valid <= 1.
  - FIFO g pops.
  - ack = 1 in the same cycle, combinationally.
  - The arbiter token therefore rotates on the same edge as the pop.
- If out_valid && out_ready && !load: out_valid <= 0.
- Back-to-back transfers: with out_ready held high and both FIFOs non-empty, one entry per cycle, alternating sources as the arbiter rotates.
- Latency: an entry pushed into an empty FIFO raises req in the next cycle. With output space free it is loaded that cycle and appears on out_valid the cycle after: 2 cycles from in_valid to out_valid.
- Stall (out_valid && !out_ready):
  - No load and ack=0; grant is ignored.
  - The arbiter token stays put, so fairness is preserved.
- Protocol errors:
  - Error condition: grant=11, or a grant bit set where req is 0.
  - grant_err <= 1 and stays set until reset.
  - No load, no pop, ack=0.
- grant=00 with req!=00 is legal: the arbiter is disabled. No load, no error.
- Reset asserted mid-operation: all stored entries are discarded and no ack is emitted.

Decomposition:
- Shared package ba_pkg:
  - Constant N_REQ=2.
  - Typedef src_idx_t (1 bit).
  - Function onehot_to_idx.
- One sub-module is natural: ba_sync_fifo (parameters DW, DEPTH; ports push, pop, wdata, rdata, full, empty, count). It is instantiated twice.
- Output stage and grant decode live in the top module.

Test Plan:
- Reset, then push 0xA1 on source 0 only, grant driven by a model arbiter.
  - req=01 one cycle later, ack pulses once.
  - out_valid=1, out_data=0xA1, out_src=0 at cycle 2; req returns to 00.
- Fill both FIFOs with 4 entries each (0x10..0x13, 0x20..0x23), out_ready=1, token starting at port 0.
  - Outputs 0x10, 0x20, 0x11, 0x21, …, one per cycle.
  - 8 ack pulses in total.
- Fill source 0 to DEPTH=4.
  - in_ready[0]=0 and a 5th push is not accepted.
  - Push and pop in the same cycle at count 3 leaves count 3.
- Hold out_ready=0 with out_valid=1 and both reqs high for 5 cycles.
  - ack stays 0; out_data is stable; FIFO counts unchanged.
  - On releasing out_ready, the next grant is taken in that same cycle.
- Force grant=10 while req=01.
  - grant_err=1 on the next edge; no ack, no pop, and the flag remains set.
- Assert rst for 1 cycle with 3 entries buffered and out_valid=1.
  - out_valid=0 and req=00 immediately (asynchronously); in_ready=11.
